// File: rtl/pwm_sync8.sv
// Glitch-free 8-bit PWM stage fed with duty codes through a one-deep valid/ready shadow register.
// Latency: an accepted code takes effect at the next period boundary, or one cycle later while disabled.
// Backpressure: DutyReady drops while a code waits in the shadow register and rises again after it loads.
//
// Ports:
//   CLOCK_50    in   1  system clock; all state changes on the rising edge
//   Resetn      in   1  asynchronous active-low reset
//   DutyIn      in   8  new duty code
//   DutyValid   in   1  DutyIn is valid this cycle
//   DutyReady   out  1  shadow register free; a transfer happens when DutyValid & DutyReady
//   Enable      in   1  1 = run the PWM, 0 = hold the counters at 0 with the output low
//   Y           out  1  PWM output, high while Q < DutyActive
//   Q           out  8  PWM period counter
//   DutyActive  out  8  duty code currently in effect
//   PeriodStart out  1  one-cycle pulse in the first cycle of each period
module pwm_sync8 #(
    parameter int PRESCALE = 196
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [7:0] DutyIn,
    input  logic       DutyValid,
    output logic       DutyReady,
    input  logic       Enable,
    output logic       Y,
    output logic [7:0] Q,
    output logic [7:0] DutyActive,
    output logic       PeriodStart
);

    // A prescale of 1 still needs a one-bit counter; it simply never leaves 0.
    localparam int              PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]   P_ONE  = PW'(1);

    logic [PW-1:0] p_cnt;
    logic [7:0]    shadow;
    logic          pending;
    logic          tick;
    logic          boundary;
    logic          accept;

    assign tick     = Enable & (p_cnt == P_LAST);
    assign boundary = tick & (Q == 8'hFF);
    assign accept   = DutyValid & ~pending;

    assign DutyReady = ~pending;
    // Both compare operands are registers, so Y can only change at a clock edge
    // (or with Enable, which gates it off immediately).
    assign Y = Enable & (Q < DutyActive);

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            p_cnt       <= '0;
            Q           <= 8'd0;
            DutyActive  <= 8'd0;
            shadow      <= 8'd0;
            pending     <= 1'b0;
            PeriodStart <= 1'b0;
        end else begin
            if (!Enable) begin
                p_cnt <= '0;
                Q     <= 8'd0;
            end else if (tick) begin
                p_cnt <= '0;
                Q     <= Q + 8'd1;
            end else begin
                p_cnt <= p_cnt + P_ONE;
            end

            PeriodStart <= boundary;

            // Accept needs pending=0 and load needs pending=1, so the two never
            // collide. A code accepted on a boundary cycle therefore waits for the
            // following boundary instead of cutting into the period just starting.
            if (accept) begin
                shadow  <= DutyIn;
                pending <= 1'b1;
            end else if (pending && (boundary || !Enable)) begin
                DutyActive <= shadow;
                pending    <= 1'b0;
            end
        end
    end

endmodule
